// File: rtl/board_write_arbiter.sv
// Round-robin arbiter for the board BRAM write port, with a full-board clear sweep; one registered write per grant, ack one cycle after req is seen.
// hold stalls new grants and freezes the clear sweep; requesters keep req high until their ack.
module board_write_arbiter #(
    parameter int NUM_CELLS = 256,
    parameter int ADDR_W    = 9,
    parameter int COLOUR_W  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*COLOUR_W-1:0] req_colour,
    input  logic                  hold,
    input  logic                  clear_start,
    input  logic [COLOUR_W-1:0]   clear_colour,
    output logic [3:0]            ack,
    output logic                  mem_wren,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [COLOUR_W-1:0]   mem_data,
    output logic                  clear_busy,
    output logic                  clear_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);
    localparam logic [ADDR_W:0]   CELLS_EXT = (ADDR_W + 1)'(NUM_CELLS);

    state_t              state_q, state_d;
    logic [1:0]          last_grant_q, last_grant_d;
    logic                clear_pending_q, clear_pending_d;
    logic [ADDR_W-1:0]   counter_q, counter_d;
    logic [COLOUR_W-1:0] fill_colour_q, fill_colour_d;
    logic [3:0]          ack_q, ack_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COLOUR_W-1:0] data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                win_vld;
    logic [1:0]          win_idx;
    logic [1:0]          cand;
    logic [ADDR_W-1:0]   win_addr;
    logic [COLOUR_W-1:0] win_colour;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_grant_q;
        cand    = last_grant_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_addr   = req_addr[int'(win_idx) * ADDR_W +: ADDR_W];
    assign win_colour = req_colour[int'(win_idx) * COLOUR_W +: COLOUR_W];

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        clear_pending_d = clear_pending_q;
        counter_d       = counter_q;
        fill_colour_d   = fill_colour_q;
        ack_d           = 4'b0000;
        wren_d          = 1'b0;
        addr_d          = addr_q;
        data_d          = data_q;
        busy_d          = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    clear_pending_d = 1'b1;
                end
                if (!hold) begin
                    if (clear_pending_q) begin
                        state_d         = ST_CLEAR;
                        clear_pending_d = 1'b0;
                        fill_colour_d   = clear_colour;
                        counter_d       = '0;
                        wren_d          = 1'b1;
                        addr_d          = '0;
                        data_d          = clear_colour;
                        busy_d          = 1'b1;
                    end else if (!clear_start && win_vld) begin
                        // A clear arriving alongside requests is latched first and wins next cycle.
                        state_d      = ST_WRITE;
                        last_grant_d = win_idx;
                        ack_d        = 4'b0001 << win_idx;
                        addr_d       = win_addr;
                        data_d       = win_colour;
                        wren_d       = ({1'b0, win_addr} < CELLS_EXT);
                    end
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
                if (clear_start) begin
                    clear_pending_d = 1'b1;
                end
            end

            ST_CLEAR: begin
                if (wren_q && (counter_q == LAST_CELL)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    // Advance only after a cell was actually written, so a hold never skips one.
                    if (wren_q) begin
                        counter_d = counter_q + ADDR_W'(1);
                    end
                    wren_d = !hold;
                    addr_d = counter_d;
                    data_d = fill_colour_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= 2'd3;
            clear_pending_q <= 1'b0;
            counter_q       <= '0;
            fill_colour_q   <= '0;
            ack_q           <= 4'b0000;
            wren_q          <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            clear_pending_q <= clear_pending_d;
            counter_q       <= counter_d;
            fill_colour_q   <= fill_colour_d;
            ack_q           <= ack_d;
            wren_q          <= wren_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign ack         = ack_q;
    assign mem_wren    = wren_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign clear_busy  = busy_q;
    assign clear_done  = done_q;

endmodule

// File: tb/tb_board_write_arbiter.sv
// Scoreboard bench for board_write_arbiter: stimulus pushes expected write events, a negedge monitor pops and compares them.
module tb_board_write_arbiter;

    localparam int NUM_CELLS = 256;
    localparam int ADDR_W    = 9;
    localparam int COLOUR_W  = 3;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [3:0]            req;
    logic [4*ADDR_W-1:0]   req_addr;
    logic [4*COLOUR_W-1:0] req_colour;
    logic                  hold;
    logic                  clear_start;
    logic [COLOUR_W-1:0]   clear_colour;
    logic [3:0]            ack;
    logic                  mem_wren;
    logic [ADDR_W-1:0]     mem_address;
    logic [COLOUR_W-1:0]   mem_data;
    logic                  clear_busy;
    logic                  clear_done;

    board_write_arbiter #(
        .NUM_CELLS(NUM_CELLS),
        .ADDR_W   (ADDR_W),
        .COLOUR_W (COLOUR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_colour  (req_colour),
        .hold        (hold),
        .clear_start (clear_start),
        .clear_colour(clear_colour),
        .ack         (ack),
        .mem_wren    (mem_wren),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]          ack;
        logic                wren;
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] data;
        logic                busy;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic w, input logic [ADDR_W-1:0] ad,
                        input logic [COLOUR_W-1:0] d, input logic b);
        ev_t e;
        e.ack  = a;
        e.wren = w;
        e.addr = ad;
        e.data = d;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [COLOUR_W-1:0] c);
        req_addr[i*ADDR_W +: ADDR_W]       = a;
        req_colour[i*COLOUR_W +: COLOUR_W] = c;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req         = 4'b0000;
        hold        = 1'b0;
        clear_start = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ack"},  ack, 0);
        chk({name, "_wren"}, mem_wren, 0);
        chk({name, "_addr"}, mem_address, 0);
        chk({name, "_data"}, mem_data, 0);
        chk({name, "_busy"}, clear_busy, 0);
        chk({name, "_done"}, clear_done, 0);
    endtask

    // Full sweep: 256 expected writes, busy length measured, optional 5-cycle hold at busy cycle hold_at.
    task automatic run_clear(input logic [COLOUR_W-1:0] col, input int hold_at,
                             input int exp_len, input string name);
        int busy_cyc;
        int d0;
        bit done_seen;
        busy_cyc  = 0;
        d0        = done_cnt;
        done_seen = 1'b0;
        for (int a = 0; a < NUM_CELLS; a++) push(4'b0000, 1'b1, ADDR_W'(a), col, 1'b1);
        clear_colour = col;
        clear_start  = 1'b1;
        tick(1);
        clear_start = 1'b0;
        for (int c = 0; c < 600 && !done_seen; c++) begin
            tick(1);
            if (clear_busy) busy_cyc++;
            if (c == 0) clear_colour = ~col;
            if (hold_at > 0 && busy_cyc == hold_at) hold = 1'b1;
            if (hold_at > 0 && busy_cyc == hold_at + 5) hold = 1'b0;
            if (clear_done) done_seen = 1'b1;
        end
        hold = 1'b0;
        tick(1);
        chk({name, "_busy_len"}, busy_cyc, exp_len);
        chk({name, "_done_once"}, done_cnt - d0, 1);
    endtask

    always @(negedge clock) begin : monitor
        ev_t got;
        ev_t e;
        if (clear_done === 1'b1) begin
            done_cnt++;
            chk("done_busy_low", clear_busy, 0);
        end
        if ((ack != 4'b0000) || mem_wren) begin
            got.ack  = ack;
            got.wren = mem_wren;
            got.addr = mem_address;
            got.data = mem_data;
            got.busy = clear_busy;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got 0x%0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                chk("write_event", got, e);
            end
        end
    end

    initial begin
        int seen;
        int bad;
        int d0;
        bit found;

        req          = 4'b0000;
        req_addr     = '0;
        req_colour   = '0;
        hold         = 1'b0;
        clear_start  = 1'b0;
        clear_colour = '0;
        reset        = 1'b1;
        tick(2);
        reset = 1'b0;
        chk_zero("reset");

        // Single request, requester 1.
        set_req(1, 9'd17, 3'b001);
        push(4'b0010, 1'b1, 9'd17, 3'b001, 1'b0);
        req = 4'b0010;
        tick(1);
        chk("single_ack", ack, 4'b0010);
        chk("single_wren", mem_wren, 1);
        req = 4'b0000;
        tick(1);
        chk("single_ack_pulse", ack, 4'b0000);

        // Fairness from reset: 0,1,2,3 then wrap to 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, ADDR_W'(40 + i), COLOUR_W'(i + 2));
            push(4'b0001 << i, 1'b1, ADDR_W'(40 + i), COLOUR_W'(i + 2), 1'b0);
        end
        req  = 4'b1111;
        seen = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            tick(1);
            if (ack != 4'b0000) begin
                req = req & ~ack;
                seen++;
            end
        end
        chk("fair_grant_count", seen, 4);
        tick(1);
        push(4'b0001, 1'b1, 9'd40, 3'd2, 1'b0);
        req   = 4'b1111;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick(1);
            if (ack != 4'b0000) begin
                chk("rr_wrap_first", ack, 4'b0001);
                req   = 4'b0000;
                found = 1'b1;
            end
        end
        chk("rr_wrap_seen", found, 1);
        tick(1);

        // Hold blocks a pending request; grant one cycle after release.
        hold = 1'b1;
        set_req(2, 9'd77, 3'd6);
        push(4'b0100, 1'b1, 9'd77, 3'd6, 1'b0);
        req = 4'b0100;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (ack != 4'b0000 || mem_wren) bad++;
        end
        chk("hold_blocks", bad, 0);
        hold = 1'b0;
        tick(1);
        chk("hold_release_ack", ack, 4'b0100);
        req = 4'b0000;
        tick(1);

        // Out-of-range address: acked, not written.
        set_req(3, 9'd300, 3'd5);
        push(4'b1000, 1'b0, 9'd300, 3'd5, 1'b0);
        req = 4'b1000;
        tick(1);
        chk("oor_ack", ack, 4'b1000);
        chk("oor_wren", mem_wren, 0);
        req = 4'b0000;
        tick(1);

        run_clear(3'b000, 0, 256, "clear0");
        run_clear(3'b110, 50, 261, "clear_hold");

        // Reset while the sweep presents address 100.
        for (int a = 0; a <= 100; a++) push(4'b0000, 1'b1, ADDR_W'(a), 3'b010, 1'b1);
        clear_colour = 3'b010;
        clear_start  = 1'b1;
        tick(1);
        clear_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            tick(1);
            if (mem_wren && mem_address == 9'd100) found = 1'b1;
        end
        chk("mid_clear_reached_100", found, 1);
        d0    = done_cnt;
        reset = 1'b1;
        tick(1);
        chk_zero("mid_reset");
        reset = 1'b0;
        tick(300);
        chk("no_done_after_reset", done_cnt - d0, 0);
        run_clear(3'b111, 0, 256, "clear_restart");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_write_arbiter.md
# board_write_arbiter

Shares the single write port (port A) of the 16x16 game-board BRAM among four requesters: red player, blue player, bomb/explosion logic, and a spare. It grants fairly in round-robin order and issues one registered write per grant. It also runs a full-board clear sweep, and it stalls all writes while the drawing FSM holds the board for a background read pass.

## Interface
- NUM_CELLS, 256, number of board cells; legal write addresses are 0..NUM_CELLS-1
- ADDR_W, 9, width of BRAM address
- COLOUR_W, 3, width of a cell colour
- clock  in  1  system clock (CLOCK_50 domain); all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  4  per-requester write request; level; held until matching ack
- req_addr  in  4*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- req_colour  in  4*COLOUR_W  requester i colour at bits [i*COLOUR_W +: COLOUR_W]
- hold  in  1  high while the drawing FSM reads the board; blocks new grants and pauses clear
- clear_start  in  1  one-cycle pulse requesting a full-board clear
- clear_colour  in  COLOUR_W  fill colour, sampled on the cycle the clear begins
- ack  out  4  one-hot, one-cycle pulse to the granted requester
- mem_wren  out  1  BRAM port A write enable
- mem_address  out  ADDR_W  BRAM port A address
- mem_data  out  COLOUR_W  BRAM port A write data
- clear_busy  out  1  high for the whole CLEAR state
- clear_done  out  1  one-cycle pulse after the last clear write

## Operation
- The FSM has three states: IDLE, WRITE and CLEAR. All outputs are registered.
- IDLE, when hold=1: no grant is made and no clear starts.
- IDLE, when hold=0 and clear_pending=1: the block samples clear_colour, zeroes the cell counter, clears clear_pending and moves to CLEAR. A pending clear takes priority over any request.
- IDLE, when hold=0, no clear pending and any req bit set: the block picks winner w.
  - The search is round-robin, starting at (last_grant+1) mod 4.
  - last_grant is set to w.
  - The state moves to WRITE.
- WRITE lasts exactly one cycle.
  - ack[w]=1.
  - mem_address=req_addr[w] and mem_data=req_colour[w]. These are latched at the grant.
  - mem_wren=1 only if req_addr[w] < NUM_CELLS. An out-of-range address is acked but not written.
  - The state always returns to IDLE. No arbitration happens in WRITE, so a requester that drops req on the cycle after ack is never granted twice.
- CLEAR writes one cell per cycle: mem_wren=1, mem_address=counter, mem_data=the latched colour, and counter+1.
  - While hold=1 in CLEAR: mem_wren=0 and the counter is frozen.
  - After the write to address NUM_CELLS-1: clear_done pulses for one cycle and the state returns to IDLE.
- clear_pending is set by clear_start in IDLE or WRITE. clear_start is ignored in CLEAR.
- A requester deasserting req before its ack withdraws the request. This is legal.

## Timing
- On reset, all outputs are 0: ack=0, mem_wren=0, mem_address=0, mem_data=0, clear_busy=0, clear_done=0. The state is IDLE, last_grant=3 (requester 0 has first priority), clear_pending=0 and the counter is 0.
- Reset asserted mid-WRITE or mid-CLEAR aborts immediately. The next cycle shows the reset values, and a partially cleared board is left as is.
- Grant latency: req seen in IDLE at edge n produces ack/mem_wren during cycle n+1.
- Write throughput is one write per 2 cycles for a single requester, and one per 2 cycles overall under contention.
- A clear takes NUM_CELLS cycles in CLEAR plus stall cycles. With hold=0 it is 256 cycles from clear_busy rise to clear_done.
- clear_done coincides with the first IDLE cycle, and clear_busy is already 0 on that cycle.
- hold rising during WRITE does not cancel the in-flight write.
- clear_start arriving in the same cycle as req, in IDLE, is latched first and wins at the next IDLE evaluation. Requests wait.
- The counter is ADDR_W bits wide and compares against NUM_CELLS-1. It never wraps past 255.

## Test plan
- Single request: after reset, req=4'b0010 with req_addr[1]=9'd17 and req_colour[1]=3'b001. Required: ack=4'b0010 for exactly one cycle, mem_wren=1, mem_address=17, mem_data=001, one cycle after req.
- Fairness: all four req held high and each dropped the cycle after its ack. Required: grants in order 0,1,2,3. Re-raising all four then yields 0 again, and no requester receives two acks in a row.
- Hold: hold=1 with req=4'b0100 pending for 10 cycles. Required: no ack and no mem_wren during hold. The grant arrives 1 cycle after hold falls.
- Clear: clear_start with clear_colour=3'b000 and hold=0. Required: 256 consecutive mem_wren cycles at addresses 0..255 with data 000, clear_busy high throughout, then a single clear_done pulse. A 5-cycle hold mid-sweep must extend this to 261 cycles with no address skipped or repeated.
- Out of range: req_addr[3]=9'd300. Required: ack[3] pulses and mem_wren stays 0.
- Reset mid-clear: reset at address 100. Required: all outputs 0 the next cycle and no clear_done. A subsequent clear_start must restart from address 0.
